// File: rtl/mem_access_unit.sv
// Memory-stage data-bus master: issues one load/store per instruction on a
// request/grant/response bus, formats load data and stalls until completion.
//
// state  | meaning
// IDLE   | waiting for a qualifying aligned access
// REQ    | dbus_req held until grant (or timeout)
// WAIT_R | load granted, waiting for rvalid (or timeout)
// DONE   | one-cycle completion, pipeline released
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [2:0] LOAD_DEF  = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;
  localparam logic [1:0] STORE_DEF = 2'd0;
  localparam logic [1:0] STORE_SB  = 2'd1;
  localparam logic [1:0] STORE_SH  = 2'd2;
  localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      state, next_state;
  logic        is_store, qualify, is_byte, is_half, aligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [2:0]  ld_type_c, ld_type_q;
  logic [1:0]  lane_q;
  logic [7:0]  to_cnt;
  logic        timeout_hit, rsp_latch;

  function automatic logic [31:0] fmt_load(input logic [2:0] t, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (t)
      LOAD_LB:  return {{24{b[7]}}, b};
      LOAD_LBU: return {24'h0, b};
      LOAD_LH:  return {{16{h[15]}}, h};
      LOAD_LHU: return {16'h0, h};
      default:  return w;
    endcase
  endfunction

  // Request decode; a load wins if both strobes are presented together.
  always_comb begin
    is_store  = mem_write && (mem_store_type != STORE_DEF);
    qualify   = mem_read || is_store;
    ld_type_c = (mem_load_type == LOAD_DEF) ? LOAD_LW : mem_load_type;
    if (mem_read) begin
      is_byte = (ld_type_c == LOAD_LB) || (ld_type_c == LOAD_LBU);
      is_half = (ld_type_c == LOAD_LH) || (ld_type_c == LOAD_LHU);
    end else begin
      is_byte = (mem_store_type == STORE_SB);
      is_half = (mem_store_type == STORE_SH);
    end
    aligned = is_half ? !addr[0] : (is_byte ? 1'b1 : (addr[1:0] == 2'b00));
    be_c    = 4'b1111;
    wdata_c = store_data;
    if (!mem_read) begin
      if (is_byte) begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end else if (is_half) begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
    end
  end

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    rsp_latch   = 1'b0;
    case (state)
      S_IDLE:
        if (qualify && aligned) next_state = S_REQ;
      S_REQ:
        if (dbus_gnt && dbus_we) begin
          next_state = S_DONE;
        end else if (to_cnt == 8'd0) begin
          next_state  = S_DONE;
          timeout_hit = 1'b1;
        end else if (dbus_gnt) begin
          next_state = S_WAIT_R;
        end
      S_WAIT_R:
        if (dbus_rvalid) begin
          next_state = S_DONE;
          rsp_latch  = 1'b1;
        end else if (to_cnt == 8'd0) begin
          next_state  = S_DONE;
          timeout_hit = 1'b1;
        end
      default:
        next_state = S_IDLE;
    endcase
    stall      = ((state == S_IDLE) && qualify && aligned) ||
                 (state == S_REQ) || (state == S_WAIT_R);
    misaligned = (state == S_IDLE) && qualify && !aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      ld_type_q  <= LOAD_LW;
      lane_q     <= '0;
      to_cnt     <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state    <= next_state;
      dbus_req <= (next_state == S_REQ);
      done     <= (next_state == S_DONE);
      bus_err  <= timeout_hit;
      if ((state == S_IDLE) && (next_state == S_REQ)) begin
        dbus_we    <= !mem_read;
        dbus_addr  <= {addr[31:2], 2'b00};
        dbus_be    <= be_c;
        dbus_wdata <= wdata_c;
        ld_type_q  <= ld_type_c;
        lane_q     <= addr[1:0];
        to_cnt     <= TO_LOAD;
      end else if (((state == S_REQ) || (state == S_WAIT_R)) && (to_cnt != 8'd0)) begin
        to_cnt <= to_cnt - 8'd1;
      end
      if (rsp_latch)
        load_data <= fmt_load(ld_type_q, lane_q, dbus_rdata);
      else if (timeout_hit)
        load_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: queued expectations checked by a monitor
// on grant and completion pulses, plus a short-timeout instance.
module tb_mem_access_unit;

  localparam logic [2:0] LDEF = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5;
  localparam logic [1:0] SDEF = 2'd0, SB = 2'd1, SH = 2'd2, SW = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  mem_load_type = '0;
  logic [1:0]  mem_store_type = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        dbus_req, dbus_we, stall, done, misaligned, bus_err;
  logic [31:0] dbus_addr, dbus_wdata, load_data;
  logic [3:0]  dbus_be;

  logic        to_mem_read = 1'b0, to_mem_write = 1'b0, to_gnt = 1'b0, to_rvalid = 1'b0;
  logic [31:0] to_rdata = '0;
  logic        to_req, to_we, to_stall, to_done, to_mis, to_err;
  logic [31:0] to_addr, to_wdata, to_load_data;
  logic [3:0]  to_be;

  int checks = 0;
  int failures = 0;

  typedef struct { logic we; logic [31:0] a; logic [3:0] be; logic chk_wd; logic [31:0] wd; } req_t;
  typedef struct { logic mis; logic chk_ld; logic [31:0] ld; } rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  mem_access_unit u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .addr(addr), .store_data(store_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .stall(stall), .load_data(load_data), .done(done),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) u_to (
    .clk(clk), .rst_n(rst_n), .mem_read(to_mem_read), .mem_write(to_mem_write),
    .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .addr(addr), .store_data(store_data),
    .dbus_req(to_req), .dbus_we(to_we), .dbus_addr(to_addr), .dbus_be(to_be),
    .dbus_wdata(to_wdata), .dbus_gnt(to_gnt), .dbus_rvalid(to_rvalid),
    .dbus_rdata(to_rdata), .stall(to_stall), .load_data(to_load_data), .done(to_done),
    .misaligned(to_mis), .bus_err(to_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: grants are compared against queued requests, completion and
  // misaligned pulses against queued responses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbus_req && dbus_gnt) begin
        if (req_q.size() == 0) begin
          chk("unexpected_grant", 32'd1, 32'd0);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_we", {31'd0, dbus_we}, {31'd0, r.we});
          chk("req_addr", dbus_addr, r.a);
          chk("req_be", {28'd0, dbus_be}, {28'd0, r.be});
          if (r.chk_wd) chk("req_wdata", dbus_wdata, r.wd);
        end
      end
      if (done || misaligned || bus_err) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, done, misaligned, bus_err}, 32'd0);
        end else begin
          rsp_t s;
          s = rsp_q.pop_front();
          chk("rsp_kind", {29'd0, done, misaligned, bus_err}, s.mis ? 32'b010 : 32'b100);
          if (s.chk_ld) chk("rsp_load_data", load_data, s.ld);
        end
      end
    end
  end

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    dbus_rdata = '0; to_mem_read = 1'b0; to_gnt = 1'b0; to_rvalid = 1'b0;
  endtask

  task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] lt,
                        input logic [1:0] st, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdat, input int gd, input int rvd, input logic spur,
                        input logic exp_mis, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_ld);
    logic noop;
    int stall_n, req_n, done_cyc, exp_done;
    noop = !rd && !(wr && st != SDEF);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_load_type = lt; mem_store_type = st;
    addr = a; store_data = sd;
    if (!noop) begin
      if (exp_mis) begin
        rsp_q.push_back('{1'b1, 1'b0, 32'd0});
      end else begin
        req_q.push_back('{!rd, {a[31:2], 2'b00}, exp_be, !rd, exp_wd});
        rsp_q.push_back('{1'b0, rd, exp_ld});
      end
    end
    @(negedge clk);
    chk({nm, "_stall0"}, {31'd0, stall}, {31'd0, !noop && !exp_mis});
    if (noop || exp_mis) begin
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk({nm, "_no_req"}, {31'd0, dbus_req}, 32'd0);
      return;
    end
    stall_n = 1; req_n = 0; done_cyc = -1;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      dbus_gnt    = (c == 1 + gd);
      dbus_rvalid = (rd && c == 1 + gd + rvd) || (spur && c == 1 + gd);
      dbus_rdata  = (rd && c == 1 + gd + rvd) ? rdat : 32'hDEADBEEF;
      @(negedge clk);
      if (stall) stall_n++;
      if (dbus_req) req_n++;
      if (done) done_cyc = c;
    end
    @(posedge clk); #1;
    clear_inputs();
    exp_done = rd ? 2 + gd + rvd : 2 + gd;
    chk({nm, "_done_cycle"}, done_cyc, exp_done);
    chk({nm, "_stall_cycles"}, stall_n, exp_done);
    chk({nm, "_req_cycles"}, req_n, gd + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc, req_n, errs, pulses;
    #13;
    chk("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_dbus_be", {28'd0, dbus_be}, 32'd0);
    chk("rst_dbus_addr", dbus_addr, 32'd0);
    chk("rst_dbus_wdata", dbus_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_pulses", {29'd0, done, misaligned, bus_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    access("sb",      0, 1, LDEF, SB,   32'h1003, 32'h000000A5, 0, 0, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
    access("lb",      1, 0, LB,   SDEF, 32'h2002, 0, 32'h0080FF00, 0, 1, 0, 0, 4'b1111, 0, 32'hFFFFFF80);
    access("lbu",     1, 0, LBU,  SDEF, 32'h2002, 0, 32'h0080FF00, 0, 1, 0, 0, 4'b1111, 0, 32'h00000080);
    access("lh",      1, 0, LH,   SDEF, 32'h2002, 0, 32'h80011234, 0, 1, 0, 0, 4'b1111, 0, 32'hFFFF8001);
    access("lhu",     1, 0, LHU,  SDEF, 32'h2002, 0, 32'h80011234, 0, 1, 0, 0, 4'b1111, 0, 32'h00008001);
    access("lw_spur", 1, 0, LW,   SDEF, 32'h2000, 0, 32'h80011234, 0, 1, 1, 0, 4'b1111, 0, 32'h80011234);
    access("ldef",    1, 0, LDEF, SDEF, 32'h2004, 0, 32'hCAFEF00D, 0, 1, 0, 0, 4'b1111, 0, 32'hCAFEF00D);
    access("lb_pos",  1, 0, LB,   SDEF, 32'h2001, 0, 32'h00007F00, 0, 1, 0, 0, 4'b1111, 0, 32'h0000007F);
    access("sh",      0, 1, LDEF, SH,   32'h1002, 32'h1234BEEF, 0, 0, 0, 0, 0, 4'b1100, 32'hBEEFBEEF, 0);
    access("sw",      0, 1, LDEF, SW,   32'h3000, 32'h11223344, 0, 1, 0, 0, 0, 4'b1111, 32'h11223344, 0);
    access("sw_mis",  0, 1, LDEF, SW,   32'h3002, 32'h11223344, 0, 0, 0, 0, 1, 0, 0, 0);
    access("lh_mis",  1, 0, LH,   SDEF, 32'h2001, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    access("sdef",    0, 1, LDEF, SDEF, 32'h3000, 32'h55555555, 0, 0, 0, 0, 0, 0, 0, 0);
    access("lw_slow", 1, 0, LW,   SDEF, 32'h4000, 0, 32'h55AA00FF, 3, 2, 0, 0, 4'b1111, 0, 32'h55AA00FF);

    // Short-timeout instance: one good load, then a load that is never granted.
    @(posedge clk); #1;
    to_mem_read = 1'b1; mem_load_type = LW; addr = 32'h2000;
    done_cyc = -1;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      to_gnt = (c == 1); to_rvalid = (c == 2); to_rdata = (c == 2) ? 32'h12345678 : 32'h0;
      @(negedge clk);
      if (to_done) done_cyc = c;
    end
    @(posedge clk); #1;
    clear_inputs();
    chk("to_good_done_cycle", done_cyc, 3);
    chk("to_good_load_data", to_load_data, 32'h12345678);

    @(posedge clk); #1;
    to_mem_read = 1'b1;
    done_cyc = -1; req_n = 0; errs = 0;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (to_req) req_n++;
      if (to_done) begin
        done_cyc = c;
        errs = int'(to_err);
        chk("to_err_load_data", to_load_data, 32'd0);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    chk("to_done_cycle", done_cyc, 5);
    chk("to_bus_err", errs, 1);
    chk("to_req_cycles", req_n, 4);
    @(negedge clk);
    chk("to_back_idle", {29'd0, to_done, to_err, to_stall}, 32'd0);

    // Reset while waiting for read data.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_load_type = LW; addr = 32'h5000;
    req_q.push_back('{1'b0, 32'h5000, 4'b1111, 1'b0, 32'd0});
    @(posedge clk); #1;
    dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0;
    #2;
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_load_data", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      dbus_rvalid = (c == 0); dbus_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      if (done || bus_err) pulses++;
    end
    clear_inputs();
    chk("rst_mid_no_done", pulses, 0);
    chk("rst_mid_load_kept0", load_data, 32'd0);

    repeat (2) @(negedge clk);
    chk("req_queue_empty", req_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
